uart_rx: RTL

//   8N1 UART receiver; the receive-side counterpart of uart_tx, same CLK_FREQ/BAUD_RATE scheme.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_sync.sv | 27 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper,
// used by both uart_tx and uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input bit,
// with a configurable reset value.
module uart_bit_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and break handling.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 1_152_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int HALF = CPB / 2;
   localparam int CW   = $clog2(CPB);
`ifdef UART_RX_MAJORITY_EN
   localparam int SKEW = 2;
`else
   localparam int SKEW = 0;
`endif
   // Start decision lands on the bit centre; later bits then fall a whole period apart.
   localparam logic [CW-1:0] START_PT = CW'(HALF - 1 + SKEW);
   localparam logic [CW-1:0] BIT_PT   = CW'(CPB - 1);

   rx_state_e     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ferr_q;
   logic          busy_q;

   logic          rx_s;
   logic [CW-1:0] pt_d;
   logic          at_pt_d;
   logic          bit_d;

   uart_bit_sync #(
      .RST_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d_i(rx_i),
      .q_o(rx_s)
   );

   always_comb begin
      pt_d    = (state_q == RX_START) ? START_PT : BIT_PT;
      at_pt_d = (cnt_q == pt_d);
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vote_q <= 2'b11;
      end else begin
         if (cnt_q == pt_d - CW'(2)) vote_q[0] <= rx_s;
         if (cnt_q == pt_d - CW'(1)) vote_q[1] <= rx_s;
      end
   end

   assign bit_d = (vote_q[0] & vote_q[1]) |
                  (vote_q[0] & rx_s) |
                  (vote_q[1] & rx_s);
`else
   assign bit_d = rx_s;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         unique case (state_q)
            RX_IDLE: begin
               cnt_q <= '0;
               if (!rx_s) begin
                  state_q <= RX_START;
                  busy_q  <= 1'b1;
               end
            end
            RX_START: begin
               if (at_pt_d) begin
                  cnt_q <= '0;
                  idx_q <= '0;
                  if (bit_d) begin
                     state_q <= RX_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= RX_DATA;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RX_DATA: begin
               if (at_pt_d) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= bit_d;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RX_STOP: begin
               if (at_pt_d) begin
                  cnt_q <= '0;
                  if (bit_d) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= RX_IDLE;
                  end else begin
                     ferr_q  <= 1'b1;
                     state_q <= RX_BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            RX_BREAK: begin
               // A held-low line must go high before another start is accepted.
               cnt_q <= '0;
               if (rx_s) begin
                  state_q <= RX_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= RX_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign busy_o      = busy_q;

endmodule
